game_sequencer: RTL

Top-level game controller for the LED reaction game. It sequences the LED game engine by synchronizing and debouncing the player button and issuing `go` pulses. It gates the engine's `run` input, judges each press from the engine's `flag` response, and tracks level, lives and score. It sits between the board I/O (button, start switch) and the engine; `lvl`, `run`, `go` and `eng_rst` connect directly to the engine.

---
 rtl/game_sequencer.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/game_sequencer.sv
// LED reaction game controller: conditions the player button and start switch,
// sequences the LED engine and keeps level, lives and score.
module game_sequencer #(
  parameter int LEVELS      = 5,
  parameter int LIVES       = 3,
  parameter int DB_CYCLES   = 500000,
  parameter int RESP_CYCLES = 4,
  parameter int HOLD_CYCLES = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn,
  input  logic       start,
  input  logic       flag,
  output logic       go,
  output logic       run,
  output logic       eng_rst,
  output logic [2:0] lvl,
  output logic [1:0] lives,
  output logic [7:0] score,
  output logic       game_over,
  output logic       game_won
);

  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam int RW  = (RESP_CYCLES > 0) ? $clog2(RESP_CYCLES + 1) : 1;
  localparam int HW  = $clog2(HOLD_CYCLES + 1);

  localparam logic [DBW-1:0] DB_LAST    = DBW'(DB_CYCLES - 1);
  localparam logic [RW-1:0]  RESP_MAX   = RW'(RESP_CYCLES);
  localparam logic [HW-1:0]  HOLD_LAST  = HW'(HOLD_CYCLES - 1);
  localparam logic [2:0]     LVL_LAST   = 3'(LEVELS - 1);
  localparam logic [1:0]     LIVES_INIT = 2'(LIVES);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PLAY      = 3'd1,
    S_CHECK     = 3'd2,
    S_WIN_HOLD  = 3'd3,
    S_MISS_HOLD = 3'd4,
    S_OVER      = 3'd5
  } state_t;

  function automatic logic state_parity(input logic [2:0] s);
    return ^s;
  endfunction

  // Button conditioning registers
  logic           btn_meta_r;
  logic           btn_sync_r;
  logic [DBW-1:0] db_cnt_r;
  logic           db_level_r;
  logic           db_level_d_r;
  logic           press_s;

  // Start edge detection registers
  logic           start_r;
  logic           start_d_r;
  logic           start_edge_s;

  // Controller state
  state_t         state_r;
  state_t         state_next;
  logic           state_par_r;
  logic [RW-1:0]  resp_r;
  logic [RW-1:0]  resp_next;
  logic [HW-1:0]  hold_r;
  logic [HW-1:0]  hold_next;
  logic [2:0]     lvl_r;
  logic [2:0]     lvl_next;
  logic [1:0]     lives_r;
  logic [1:0]     lives_next;
  logic [7:0]     score_r;
  logic [7:0]     score_next;
  logic           won_r;
  logic           won_next;
  logic           go_r;
  logic           go_next;
  logic           run_r;
  logic           eng_rst_r;
  logic           over_r;

  assign press_s      = db_level_r & ~db_level_d_r;
  assign start_edge_s = start_r & ~start_d_r;

  // Synchronize the raw button and debounce it; any bounce restarts the count
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_meta_r   <= 1'b0;
      btn_sync_r   <= 1'b0;
      db_cnt_r     <= {DBW{1'b0}};
      db_level_r   <= 1'b0;
      db_level_d_r <= 1'b0;
    end else begin
      btn_meta_r   <= btn;
      btn_sync_r   <= btn_meta_r;
      db_level_d_r <= db_level_r;
      if (btn_sync_r == db_level_r) begin
        db_cnt_r <= {DBW{1'b0}};
      end else if (db_cnt_r == DB_LAST) begin
        db_cnt_r   <= {DBW{1'b0}};
        db_level_r <= btn_sync_r;
      end else begin
        db_cnt_r <= db_cnt_r + DBW'(1);
      end
    end
  end

  // Register start and its one-cycle delay for rising-edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      start_r   <= 1'b0;
      start_d_r <= 1'b0;
    end else begin
      start_r   <= start;
      start_d_r <= start_r;
    end
  end

  // Next-state and datapath decisions for the game sequence
  always_comb begin
    state_next  = state_r;
    resp_next   = resp_r;
    hold_next   = hold_r;
    lvl_next    = lvl_r;
    lives_next  = lives_r;
    score_next  = score_r;
    won_next    = won_r;
    go_next     = 1'b0;
    if (state_par_r != state_parity(state_r)) begin
      // Corrupted state register: fall back to a fresh idle game
      state_next = S_IDLE;
      lvl_next   = 3'd0;
      lives_next = LIVES_INIT;
      score_next = 8'd0;
      won_next   = 1'b0;
    end else begin
      case (state_r)
        S_IDLE, S_OVER: begin
          if (start_edge_s) begin
            state_next = S_PLAY;
            lvl_next   = 3'd0;
            lives_next = LIVES_INIT;
            score_next = 8'd0;
            won_next   = 1'b0;
          end else begin
            state_next = state_r;
          end
        end
        S_PLAY: begin
          if (press_s) begin
            go_next    = 1'b1;
            resp_next  = {RW{1'b0}};
            state_next = S_CHECK;
          end else begin
            state_next = S_PLAY;
          end
        end
        S_CHECK: begin
          if (flag && (resp_r < RESP_MAX)) begin
            state_next = S_WIN_HOLD;
            hold_next  = {HW{1'b0}};
            if (score_r != 8'hFF) begin
              score_next = score_r + 8'd1;
            end else begin
              score_next = score_r;
            end
          end else if (resp_r >= RESP_MAX) begin
            state_next = S_MISS_HOLD;
            hold_next  = {HW{1'b0}};
            if (lives_r != 2'd0) begin
              lives_next = lives_r - 2'd1;
            end else begin
              lives_next = 2'd0;
            end
          end else begin
            resp_next = resp_r + RW'(1);
          end
        end
        S_WIN_HOLD: begin
          if (hold_r == HOLD_LAST) begin
            if (lvl_r >= LVL_LAST) begin
              state_next = S_OVER;
              won_next   = 1'b1;
            end else begin
              state_next = S_PLAY;
              lvl_next   = lvl_r + 3'd1;
            end
          end else begin
            hold_next = hold_r + HW'(1);
          end
        end
        S_MISS_HOLD: begin
          if (hold_r == HOLD_LAST) begin
            if (lives_r == 2'd0) begin
              state_next = S_OVER;
              won_next   = 1'b0;
            end else begin
              state_next = S_PLAY;
            end
          end else begin
            hold_next = hold_r + HW'(1);
          end
        end
        default: begin
          state_next = S_IDLE;
          lvl_next   = 3'd0;
          lives_next = LIVES_INIT;
          score_next = 8'd0;
          won_next   = 1'b0;
        end
      endcase
    end
  end

  // State, counters and registered engine/status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= S_IDLE;
      state_par_r <= state_parity(S_IDLE);
      resp_r      <= {RW{1'b0}};
      hold_r      <= {HW{1'b0}};
      lvl_r       <= 3'd0;
      lives_r     <= LIVES_INIT;
      score_r     <= 8'd0;
      won_r       <= 1'b0;
      go_r        <= 1'b0;
      run_r       <= 1'b0;
      eng_rst_r   <= 1'b1;
      over_r      <= 1'b0;
    end else begin
      state_r     <= state_next;
      state_par_r <= state_parity(state_next);
      resp_r      <= resp_next;
      hold_r      <= hold_next;
      lvl_r       <= lvl_next;
      lives_r     <= lives_next;
      score_r     <= score_next;
      won_r       <= won_next;
      go_r        <= go_next;
      run_r       <= (state_next == S_PLAY);
      eng_rst_r   <= (state_next == S_IDLE);
      over_r      <= (state_next == S_OVER);
    end
  end

  assign go        = go_r;
  assign run       = run_r;
  assign eng_rst   = eng_rst_r;
  assign lvl       = lvl_r;
  assign lives     = lives_r;
  assign score     = score_r;
  assign game_over = over_r;
  assign game_won  = won_r;

endmodule
